// File: rtl/buffer_read_serializer.sv
`timescale 1ns/1ps
// Pops R_PARAM-word chunks from the PE circular buffer and replays them word by word to the MAC input.
// Latency: the first word is valid one cycle after the pop. Backpressure: out_ready=0 freezes the word and count, and no pop is issued.
// Optional PREFETCH_EN: pops the next chunk on the last-word transfer, giving a zero-bubble stream.
module buffer_read_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int R_PARAM    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          buf_valid,
    input  logic                          buf_empty,
    input  logic [DATA_WIDTH*R_PARAM-1:0] buf_data,
    output logic                          buf_read_en,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int CW = $clog2(R_PARAM);
    localparam logic [CW-1:0] LAST_IDX = CW'(R_PARAM - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                        state_q, state_d;
    logic [DATA_WIDTH*R_PARAM-1:0] hold_q, hold_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          rd_en;
    logic                          pop;
    logic                          xfer;
    logic                          at_last;

    assign pop     = buf_valid & ~buf_empty & ~flush;
    assign xfer    = (state_q == SHIFT) & out_ready;
    assign at_last = (cnt_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                rd_en = pop;
                if (pop) begin
                    hold_d  = buf_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
`ifdef PREFETCH_EN
                        rd_en = pop;
                        if (pop) begin
                            hold_d = buf_data;
                            cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides any transfer or pop; the held words are simply abandoned.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gating with rst keeps the pop request low for the whole time reset is held.
    assign buf_read_en = rd_en & rst;
    assign busy        = (state_q == SHIFT);
    assign out_valid   = busy;
    assign out_last    = busy & at_last;
    assign out_data    = busy ? hold_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule
